// File: rtl/single_dot_v_m_stream_if.sv
// Stream bundle for single_dot_v_m_stream: beat input (x plus one weight row) and result output.
interface single_dot_v_m_stream_if #(
  parameter int LANES = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_x;
  logic [LANES*32-1:0]   in_w;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*32-1:0]   out_data;

  modport master (
    output in_valid, in_x, in_w, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_x, in_w, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/single_dot_v_m_stream.sv
// Streaming binary32 vector x matrix-slice engine, LANES MAC lanes, one beat per cycle.
// Optional per-lane bias added in FINISH when SINGLE_DOT_V_M_STREAM_BIAS_EN is defined.
module single_dot_v_m_stream #(
  parameter int WIDTH = 784,
  parameter int LANES = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                relu_en,
`ifdef SINGLE_DOT_V_M_STREAM_BIAS_EN
  input  logic [LANES*32-1:0] bias,
`endif
  output logic                busy,
  output logic                err,
  single_dot_v_m_stream_if.slave s
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} state_t;

  // Flush-to-zero, round-to-nearest-even multiply; overflow saturates to signed infinity.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic [7:0]        ea;
    logic [7:0]        eb;
    logic [47:0]       p;
    logic [23:0]       m;
    logic              g;
    logic              st;
    logic signed [9:0] e;
    logic [24:0]       mr;
    sgn = a[31] ^ b[31];
    ea  = a[30:23];
    eb  = b[30:23];
    p   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    e  = e + $signed({9'd0, mr[24]});
    if (ea == 8'd0 || eb == 8'd0) return {sgn, 31'd0};
    if (ea == 8'hFF || eb == 8'hFF || e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {sgn, 31'd0};
    return {sgn, e[7:0], (mr[24] ? mr[23:1] : mr[22:0])};
  endfunction

  // Flush-to-zero, round-to-nearest-even add using guard/round/sticky alignment bits.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x;
    logic [31:0]       y;
    logic [7:0]        d8;
    logic [26:0]       xa;
    logic [26:0]       ya;
    logic [27:0]       sm;
    logic [4:0]        sh;
    logic              found;
    logic signed [9:0] e;
    logic [24:0]       mr;
    x = (a[30:23] == 8'd0) ? {a[31], 31'd0} : a;
    y = (b[30:23] == 8'd0) ? {b[31], 31'd0} : b;
    if (x[30:23] == 8'hFF) return x;
    if (y[30:23] == 8'hFF) return y;
    if (x[30:0] == 31'd0 && y[30:0] == 31'd0) return {x[31] & y[31], 31'd0};
    if (x[30:0] == 31'd0) return y;
    if (y[30:0] == 31'd0) return x;
    if (y[30:0] > x[30:0]) {x, y} = {y, x};
    d8 = x[30:23] - y[30:23];
    xa = {1'b1, x[22:0], 3'b000};
    ya = {1'b1, y[22:0], 3'b000};
    if (d8 >= 8'd27) ya = 27'd1;
    else ya = (ya >> d8) | {26'd0, |(ya & ((27'd1 << d8) - 27'd1))};
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      sm = {1'b0, xa} + {1'b0, ya};
      if (sm[27]) begin
        sm = {1'b0, sm[27:2], sm[1] | sm[0]};
        e  = e + 10'sd1;
      end
    end else begin
      sm = {1'b0, xa} - {1'b0, ya};
      if (sm == 28'd0) return 32'd0;
      sh    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && sm[i]) begin
          sh    = 5'(26 - i);
          found = 1'b1;
        end
      end
      sm = sm << sh;
      e  = e - $signed({5'd0, sh});
    end
    mr = {1'b0, sm[26:3]} + {24'd0, sm[2] & (sm[1] | sm[0] | sm[3])};
    e  = e + $signed({9'd0, mr[24]});
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 10'sd0) return {x[31], 31'd0};
    return {x[31], e[7:0], (mr[24] ? mr[23:1] : mr[22:0])};
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                relu_q, relu_d;
  logic [LANES*32-1:0] out_q, out_d;
  logic [31:0]         acc_q [LANES];
  logic [31:0]         acc_d [LANES];
  logic [31:0]         mac   [LANES];
  logic [LANES*32-1:0] fin;
  logic                lastBeat;

  assign lastBeat   = (cnt_q == CW'(WIDTH - 1));
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign s.out_data = out_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0] biased;
`ifdef SINGLE_DOT_V_M_STREAM_BIAS_EN
    assign biased = fadd(acc_q[g], bias[32*g +: 32]);
`else
    assign biased = acc_q[g];
`endif
    // ReLU clamps anything with the sign bit set, which also turns -0 into +0.
    assign fin[32*g +: 32] = (relu_q && biased[31]) ? 32'd0 : biased;
    assign mac[g]          = fadd(acc_q[g], fmul(s.in_x, s.in_w[32*g +: 32]));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    relu_d      = relu_q;
    out_d       = out_q;
    s.in_ready  = 1'b0;
    s.out_valid = 1'b0;
    for (int i = 0; i < LANES; i++) acc_d[i] = acc_q[i];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          err_d   = 1'b0;
          relu_d  = relu_en;
          for (int i = 0; i < LANES; i++) acc_d[i] = 32'd0;
        end
      end
      ACCUM: begin
        s.in_ready = 1'b1;
        if (s.in_valid) begin
          for (int i = 0; i < LANES; i++) acc_d[i] = mac[i];
          cnt_d = cnt_q + CW'(1);
          // Length mismatch is flagged but the pass still ends on the beat count.
          if (s.in_last != lastBeat) err_d = 1'b1;
          if (lastBeat) state_d = FINISH;
        end
      end
      FINISH: begin
        out_d   = fin;
        state_d = OUT;
      end
      OUT: begin
        s.out_valid = 1'b1;
        if (s.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      relu_q  <= 1'b0;
      out_q   <= '0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      relu_q  <= relu_d;
      out_q   <= out_d;
      for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
    end
  end

endmodule

// File: doc/single_dot_v_m_stream.md
Name: single_dot_v_m_stream

Overview:
Streaming single-precision (IEEE-754 binary32) vector-by-matrix-slice engine with LANES parallel multiply-accumulate lanes.
- Vector elements and matching weight rows arrive one beat at a time over a valid/ready handshake, so full WIDTH×HEIGHT arrays are no longer presented as ports.
- Larger HEIGHT is covered by the upstream controller issuing ceil(HEIGHT/LANES) passes.
- Adds per-pass ReLU, length checking and output backpressure; optional per-lane bias.

Parameters:
- WIDTH, 784, vector length (beats per pass), ≥1.
- LANES, 10, parallel output neurons per pass, ≥1.

Ports:
- clk, input, 1, rising-edge clock.
- rstn, input, 1, asynchronous active-low reset.
- start, input, 1, begin a pass; sampled only in IDLE.
- relu_en, input, 1, apply ReLU to this pass; latched on accepted start.
- in_valid, input, 1, beat valid.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- in_x, input, 32, vector element.
- in_w, input, LANES*32, weights; lane i at bits [32i+31:32i].
- in_last, input, 1, upstream marks final beat.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts result.
- out_data, output, LANES*32, lane results, same packing as in_w.
- busy, output, 1, high in any state except IDLE.
- err, output, 1, sticky length-mismatch flag.

Behaviour:
- Clock and reset: one clock (clk); reset (rstn) is asynchronous and active-low.
- States: IDLE, ACCUM, FINISH, OUT.
- IDLE:
  - start=1 → ACCUM next cycle.
  - On the start edge: accumulators := +0, beat counter := 0, err := 0, relu_en latched.
  - start in any other state is ignored.
- ACCUM:
  - in_ready=1.
  - Per accepted beat: acc[i] := fadd(acc[i], fmul(in_x, w[i])).
  - Product rounded, then sum rounded (no fused MAC). Strict index order 0..WIDTH-1.
  - in_valid low stalls with no state change.
  - Accepting beat WIDTH-1 → FINISH.
- FINISH (1 cycle), in_ready=0:
  - Optional bias add.
  - If the latched relu_en=1: any result with sign bit set (including -0) becomes 0x00000000.
  - Result registered to out_data → OUT.
- OUT:
  - out_valid=1, out_data held stable until out_ready=1, then IDLE next cycle.
  - out_valid && out_ready with start=1 on the same cycle: start is ignored (FSM still in OUT).
- Latency:
  - start accepted at cycle t → in_ready=1 at t+1.
  - Last beat accepted at cycle u → out_valid=1 at u+2.
- err:
  - Set if in_last=1 on an accepted beat with counter ≠ WIDTH-1.
  - Set if in_last=0 on beat WIDTH-1.
  - Pass still completes on count; err holds until next accepted start.
- Arithmetic:
  - Round-to-nearest-even.
  - Subnormal inputs/results flushed to signed zero.
  - Overflow → signed infinity.
  - NaN inputs unsupported (result undefined, no hang).
  - Combinational fmul/fadd inside the block; one beat per cycle.
- Reset values: state IDLE; in_ready=0, out_valid=0, busy=0, err=0, out_data=0, accumulators=0, counter=0.
- Reset mid-pass: immediate return to IDLE with all of the above; partial pass discarded.
- Counter width: clog2(WIDTH+1); no wrap within a pass.

Optional Feature:
- Macro: SINGLE_DOT_V_M_STREAM_BIAS_EN.
- Defined:
  - Adds input port bias, LANES*32, sampled in FINISH.
  - FINISH computes acc[i] := fadd(acc[i], bias[i]) before ReLU.
- Undefined:
  - No bias port; FINISH passes accumulators straight to ReLU/output.
  - Timing identical either way.

Test Plan:
- WIDTH=4, LANES=2. x=1,2,3,4 (0x3F800000,0x40000000,0x40400000,0x40800000); lane0 w=1.0, lane1 w=0.5; relu_en=0 → lane0 0x41200000 (10.0), lane1 0x40A00000 (5.0); out_valid exactly 2 cycles after the last beat; err=0.
- Same x, lane0 w=-1.0:
  - relu_en=0 → lane0 0xC1200000.
  - relu_en=1 → lane0 0x00000000, lane1 0x40A00000 unaffected.
- Backpressure: in_valid low for 3 cycles between beats 1 and 2, out_ready low for 5 cycles → out_data stable throughout, values as in scenario 1; busy high until the handshake completes.
- in_last asserted on beat index 2 → err=1, out_valid still only after the 4th beat; next start clears err to 0.
- rstn pulsed low after 2 beats → in_ready, out_valid, busy drop asynchronously, out_data=0; a fresh full pass afterwards gives scenario 1 results.
- With SINGLE_DOT_V_M_STREAM_BIAS_EN, bias lane0=0x3F000000 (0.5), lane1=0xC1000000 (-8.0), relu_en=1 → lane0 0x41280000 (10.5), lane1 0x00000000 (-3.0 clamped).
